// File: rtl/sum_prod_seq.sv
// sum_prod_seq: handshaked shift-add engine computing X0*X1 + X2*X3 + X4*X5
module sum_prod_seq #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   X [5:0],
  input  logic           in_valid,
  output logic           in_ready,
  output logic [2*N+2:0] result,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           busy
);
  localparam int W  = 2*N+3;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0]    state;
  logic [N-1:0]  ops [5:0];
  logic [W-1:0]  acc;
  logic [W-1:0]  pp;
  logic [1:0]    k;
  logic [IW-1:0] i;
  logic [N-1:0]  opa;
  logic [N-1:0]  opb;
  logic          last_bit;
  // partial product for the current pair k and multiplier bit i
  always_comb begin
    opa      = ops[{k, 1'b0}];
    opb      = ops[{k, 1'b1}];
    pp       = opb[i] ? W'(opa) << i : '0;
    last_bit = i == IW'(N-1);
  end
  // control FSM, operand latch and accumulator; k wraps to 0 so it never indexes past pair 2
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      k     <= '0;
      i     <= '0;
      ops   <= '{default: '0};
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          ops   <= X;
          acc   <= '0;
          k     <= '0;
          i     <= '0;
          state <= CALC;
        end
        CALC: begin
          acc <= acc + pp;
          i   <= last_bit ? '0 : i + 1'b1;
          if (last_bit) k <= (k == 2'd2) ? 2'd0 : k + 1'b1;
          if (last_bit && k == 2'd2) state <= DONE;
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  assign in_ready  = state == IDLE;
  assign busy      = state == CALC;
  assign out_valid = state == DONE;
  assign result    = acc;
endmodule

// File: tb/tb_sum_prod_seq.sv
// tb_sum_prod_seq: random and directed checks of sum_prod_seq against an arithmetic model
module tb_sum_prod_seq;
  localparam int N = 4;
  logic           clk = 0;
  logic           rst_n = 0;
  logic [N-1:0]   X [5:0];
  logic           in_valid = 0;
  logic           in_ready;
  logic [2*N+2:0] result;
  logic           out_valid;
  logic           out_ready = 0;
  logic           busy;
  int errors = 0;
  int checks = 0;

  sum_prod_seq #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .X(X), .in_valid(in_valid), .in_ready(in_ready),
    .result(result), .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] pk(input int a, b, c, d, e, f);
    return {f[3:0], e[3:0], d[3:0], c[3:0], b[3:0], a[3:0]};
  endfunction

  function automatic int model(input logic [23:0] p);
    int s = 0;
    for (int j = 0; j < 3; j++) s += int'(p[8*j +: 4]) * int'(p[8*j+4 +: 4]);
    return s;
  endfunction

  task automatic set_x(input logic [23:0] p);
    for (int j = 0; j < 6; j++) X[j] = p[4*j +: 4];
  endtask

  // one full transaction; X is scrambled every CALC cycle, stall cycles of backpressure in DONE
  task automatic transact(input logic [23:0] p, input int stall);
    int n = 0;
    int nb = 0;
    int bad = 0;
    int r;
    out_ready = (stall == 0);
    set_x(p);
    in_valid = 1;
    check("in_ready_idle", in_ready, 1);
    @(negedge clk);
    in_valid = 0;
    while (!out_valid && n < 40) begin
      if (busy) nb++;
      if (in_ready) bad++;
      set_x($urandom);
      in_valid = $urandom_range(0, 1);
      @(negedge clk);
      n++;
    end
    in_valid = 0;
    check("latency", n, 3*N);
    check("busy_cycles", nb, 3*N);
    check("in_ready_calc", bad, 0);
    check("result", int'(result), model(p));
    check("busy_done", busy, 0);
    r = int'(result);
    for (int s = 0; s < stall; s++) begin
      in_valid = (s == 2);
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_result", int'(result), r);
      check("hold_in_ready", in_ready, 0);
    end
    in_valid = 0;
    out_ready = 1;
    @(negedge clk);
    check("idle_valid", out_valid, 0);
    check("idle_in_ready", in_ready, 1);
    check("idle_result", int'(result), r);
  endtask

  initial begin
    logic [23:0] a;
    logic [23:0] b;
    int t;
    int got;
    int t1;
    int t2;
    set_x('0);
    repeat (2) @(negedge clk);
    check("rst_result", int'(result), 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    rst_n = 1;
    @(negedge clk);
    check("idle_stays", in_ready, 1);

    transact(pk(3, 2, 4, 1, 7, 5), 0);
    transact('1, 0);
    transact('0, 1);
    transact(pk(15, 0, 0, 15, 1, 1), 0);
    transact(pk(3, 2, 4, 1, 7, 5), 5);

    set_x(pk(3, 2, 4, 1, 7, 5));
    out_ready = 1;
    in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    set_x('1);
    repeat (6) @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    check("midrst_busy", busy, 0);
    check("midrst_result", int'(result), 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    transact(pk(1, 1, 1, 1, 1, 1), 0);

    for (int r = 0; r < 20; r++) transact($urandom, $urandom_range(0, 3));

    a = pk(3, 2, 4, 1, 7, 5);
    b = $urandom;
    set_x(a);
    out_ready = 1;
    in_valid = 1;
    @(negedge clk);
    set_x(b);
    t = 0;
    got = 0;
    t1 = 0;
    t2 = 0;
    while (got < 2 && t < 100) begin
      t++;
      if (out_valid) begin
        got++;
        if (got == 1) begin
          t1 = t;
          check("b2b_first", int'(result), model(a));
        end else begin
          t2 = t;
          in_valid = 0;
          check("b2b_second", int'(result), model(b));
        end
      end
      @(negedge clk);
    end
    in_valid = 0;
    check("b2b_count", got, 2);
    check("b2b_spacing", t2 - t1, 3*N+2);
    @(negedge clk);
    check("b2b_idle", in_ready, 1);
    check("b2b_no_extra", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
